// File: rtl/icache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package icache_pkg;

    localparam int unsigned DEF_ADDR_W     = 64;
    localparam int unsigned DEF_INST_W     = 32;
    localparam int unsigned DEF_SETS       = 8;
    localparam int unsigned DEF_WAYS       = 2;
    localparam int unsigned DEF_LINE_WORDS = 4;

    localparam int unsigned OFF_W  = $clog2(DEF_INST_W / 8);
    localparam int unsigned WORD_W = $clog2(DEF_LINE_WORDS);
    localparam int unsigned SET_W  = $clog2(DEF_SETS);
    localparam int unsigned TAG_W  = DEF_ADDR_W - OFF_W - WORD_W - SET_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV
    } state_t;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Replacement choice for one set: lowest invalid way, else the round-robin pointer.
module icache_victim_sel #(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned WAY_BITS = 1
) (
    input  logic [WAYS-1:0]     valid,
    input  logic [WAY_BITS-1:0] rr_ptr,
    output logic [WAY_BITS-1:0] victim
);

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        victim = rr_ptr;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid[w]) victim = WAY_BITS'(w);
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Blocking set-associative I-cache: combinational hit path, single-line refill FSM.
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned INST_W     = DEF_INST_W,
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned WAYS       = DEF_WAYS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] PcIn,
    input  logic              PcValid,
    input  logic              Flush,
    output logic [INST_W-1:0] InstOut,
    output logic              InstValid,
    output logic              CacheMiss,
    output logic              MemReqValid,
    input  logic              MemReqReady,
    output logic [ADDR_W-1:0] MemReqAddr,
    input  logic              MemRspValid,
    input  logic [INST_W-1:0] MemRspData
);

    localparam int unsigned OFF_BITS  = $clog2(INST_W / 8);
    localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
    localparam int unsigned SET_BITS  = $clog2(SETS);
    localparam int unsigned LINE_SH   = OFF_BITS + WORD_BITS;
    localparam int unsigned TAG_SH    = LINE_SH + SET_BITS;
    localparam int unsigned TAG_BITS  = ADDR_W - TAG_SH;
    localparam int unsigned WI_BITS   = idx_w(LINE_WORDS);
    localparam int unsigned WAY_BITS  = idx_w(WAYS);

    state_t state, state_nxt;

    logic [INST_W-1:0]   data_q  [SETS][WAYS][LINE_WORDS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAY_BITS-1:0] rr_q    [SETS];

    logic [ADDR_W-1:0]   line_q;
    logic [SET_BITS-1:0] set_q;
    logic [WAY_BITS-1:0] victim_q;
    logic [WI_BITS-1:0]  beat_q;
    logic                discard_q;
    logic                req_q;

    logic [WI_BITS-1:0]  pc_word;
    logic [SET_BITS-1:0] pc_set;
    logic [TAG_BITS-1:0] pc_tag;
    logic [TAG_BITS-1:0] line_tag;
    logic [WAY_BITS-1:0] victim_c;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] rr_nxt;
    logic                hit_any;
    logic                hit_c;
    logic                beat_c;
    logic                last_beat;

    assign pc_word  = WI_BITS'((PcIn >> OFF_BITS) & ADDR_W'(LINE_WORDS - 1));
    assign pc_set   = SET_BITS'(PcIn >> LINE_SH);
    assign pc_tag   = TAG_BITS'(PcIn >> TAG_SH);
    assign line_tag = TAG_BITS'(line_q >> TAG_SH);
    assign rr_nxt   = WAY_BITS'((32'(victim_q) + 32'd1) % WAYS);

    icache_victim_sel #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_victim_sel (
        .valid  (valid_q[pc_set]),
        .rr_ptr (rr_q[pc_set]),
        .victim (victim_c)
    );

    // Tag compare across the ways of the addressed set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[pc_set][w] && (tag_q[pc_set][w] == pc_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    assign hit_c       = PcValid && hit_any && (state == IDLE) && !Flush;
    assign InstValid   = hit_c;
    assign InstOut     = hit_c ? data_q[pc_set][hit_way][pc_word] : '0;
    assign CacheMiss   = (PcValid && !hit_c) || (state != IDLE);
    assign MemReqValid = req_q;
    assign MemReqAddr  = line_q;

    assign beat_c    = (state == RECV) && MemRspValid;
    assign last_beat = beat_c && (beat_q == WI_BITS'(LINE_WORDS - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (PcValid && !hit_any && !Flush) state_nxt = REQ;
            REQ:     if (MemReqReady) state_nxt = RECV;
            RECV:    if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Refill bookkeeping: latch the missing line, count beats, remember flushes.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            req_q     <= 1'b0;
            line_q    <= '0;
            set_q     <= '0;
            victim_q  <= '0;
            beat_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            req_q <= (state_nxt == REQ);
            if ((state == IDLE) && (state_nxt == REQ)) begin
                line_q    <= (PcIn >> LINE_SH) << LINE_SH;
                set_q     <= pc_set;
                victim_q  <= victim_c;
                beat_q    <= '0;
                discard_q <= 1'b0;
            end else if (Flush) begin
                discard_q <= 1'b1;
            end
            if (beat_c) beat_q <= last_beat ? '0 : beat_q + WI_BITS'(1);
        end
    end

    // Flush beats a completing refill, so a coincident last beat is discarded.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (Flush) begin
                for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (last_beat && !discard_q) begin
                valid_q[set_q][victim_q] <= 1'b1;
            end
            if (last_beat) rr_q[set_q] <= rr_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst && beat_c) data_q[set_q][victim_q][beat_q] <= MemRspData;
        if (Rst && last_beat) tag_q[set_q][victim_q] <= line_tag;
    end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed vectors plus a randomized run against a line-level model.
module tb_icache_sa;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [63:0] PcIn;
    logic        PcValid;
    logic        Flush;
    logic [31:0] InstOut;
    logic        InstValid;
    logic        CacheMiss;
    logic        MemReqValid;
    logic        MemReqReady;
    logic [63:0] MemReqAddr;
    logic        MemRspValid;
    logic [31:0] MemRspData;

    int checks = 0;
    int errors = 0;

    logic [31:0] beat_buf [4];

    typedef struct {
        logic [63:0] pc;
        logic        pv;
        logic        exp_v;
        logic [31:0] exp_inst;
        logic        exp_miss;
    } vec_t;

    vec_t tbl [8];

    // Model state: one tag per (set, way), valid bit and round-robin pointer per set.
    bit          m_val [8][2];
    logic [63:0] m_tag [8][2];
    int          m_rr  [8];

    icache_sa dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .PcIn        (PcIn),
        .PcValid     (PcValid),
        .Flush       (Flush),
        .InstOut     (InstOut),
        .InstValid   (InstValid),
        .CacheMiss   (CacheMiss),
        .MemReqValid (MemReqValid),
        .MemReqReady (MemReqReady),
        .MemReqAddr  (MemReqAddr),
        .MemRspValid (MemRspValid),
        .MemRspData  (MemRspData)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (lo * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, need %0b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [63:0] pc, input logic pv, input logic fl);
        @(negedge Clk);
        PcIn        = pc;
        PcValid     = pv;
        Flush       = fl;
        MemRspValid = 1'b0;
        MemReqReady = 1'b0;
        #2;
    endtask

    task automatic look(input string nm, input logic [63:0] pc, input logic pv, input logic fl,
                        input logic ev, input logic [31:0] ei, input logic em);
        cyc(pc, pv, fl);
        chkb({nm, "/inst_valid"}, InstValid, ev);
        chkw({nm, "/inst_out"}, 64'(InstOut), 64'(ei));
        chkb({nm, "/cache_miss"}, CacheMiss, em);
    endtask

    task automatic set_beats(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 4; i++) beat_buf[i] = base + step * 32'(i);
    endtask

    // Memory side of one refill. gap_mode: 0 none, 1 one idle cycle before each later beat, 2 random idles.
    task automatic serve(input string nm, input logic [63:0] addr, input int rwait,
                         input int gap_mode, input int flush_at);
        int b;
        bit gap_done;
        bit want_gap;
        @(negedge Clk);
        MemReqReady = (rwait == 0);
        #2;
        chkb({nm, "/req_valid"}, MemReqValid, 1'b1);
        chkw({nm, "/req_addr"}, MemReqAddr, addr);
        chkb({nm, "/req_stall"}, CacheMiss, 1'b1);
        for (int w = 1; w <= rwait; w++) begin
            @(negedge Clk);
            MemReqReady = (w == rwait);
            #2;
            chkb({nm, "/req_hold_valid"}, MemReqValid, 1'b1);
            chkw({nm, "/req_hold_addr"}, MemReqAddr, addr);
        end
        b = 0;
        gap_done = 1'b0;
        while (b < 4) begin
            @(negedge Clk);
            MemReqReady = 1'b0;
            Flush       = 1'b0;
            if (gap_mode == 1) want_gap = (b > 0) && !gap_done;
            else               want_gap = (gap_mode == 2) && ($urandom_range(0, 2) == 0);
            if (want_gap) begin
                MemRspValid = 1'b0;
                MemRspData  = 32'hDEAD_BEEF;
                gap_done    = 1'b1;
                #2;
                chkb({nm, "/gap_no_hit"}, InstValid, 1'b0);
                chkb({nm, "/gap_stall"}, CacheMiss, 1'b1);
            end else begin
                MemRspValid = 1'b1;
                MemRspData  = beat_buf[b];
                Flush       = (b == flush_at);
                gap_done    = 1'b0;
                b++;
                #2;
                chkb({nm, "/recv_req_low"}, MemReqValid, 1'b0);
            end
        end
    endtask

    initial begin
        logic [63:0] pc, line, tag;
        logic        pv, fl, hit, ev;
        int          set, victim, fa;

        tbl[0] = '{64'h8000_0000, 1'b1, 1'b1, 32'h11, 1'b0};
        tbl[1] = '{64'h8000_0004, 1'b1, 1'b1, 32'h22, 1'b0};
        tbl[2] = '{64'h8000_0008, 1'b1, 1'b1, 32'h33, 1'b0};
        tbl[3] = '{64'h8000_000C, 1'b1, 1'b1, 32'h44, 1'b0};
        tbl[4] = '{64'h8000_0000, 1'b0, 1'b0, 32'h0,  1'b0};
        tbl[5] = '{64'h8000_0010, 1'b0, 1'b0, 32'h0,  1'b0};
        tbl[6] = '{64'h8000_0004, 1'b1, 1'b1, 32'h22, 1'b0};
        tbl[7] = '{64'h8000_0080, 1'b1, 1'b0, 32'h0,  1'b1};

        Rst = 1'b0; PcIn = '0; PcValid = 1'b0; Flush = 1'b0;
        MemReqReady = 1'b0; MemRspValid = 1'b0; MemRspData = '0;

        cyc(64'h0, 1'b0, 1'b0);
        look("reset", 64'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chkb("reset/req_valid", MemReqValid, 1'b0);
        Rst = 1'b1;

        // Cold miss, then a hit the cycle after the last beat.
        look("cold_miss", 64'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        set_beats(32'h11, 32'h11);
        serve("cold", 64'h8000_0000, 0, 0, -1);
        look("cold_hit", 64'h8000_0008, 1'b1, 1'b0, 1'b1, 32'h33, 1'b0);

        for (int i = 0; i < 8; i++) begin
            look($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].pv, 1'b0,
                 tbl[i].exp_v, tbl[i].exp_inst, tbl[i].exp_miss);
            if (i < 7) chkb($sformatf("tbl%0d/no_req", i), MemReqValid, 1'b0);
        end

        // Second way of set 0, then round-robin eviction with a stalled handshake.
        set_beats(32'hA0, 32'h1);
        serve("way1", 64'h8000_0080, 0, 0, -1);
        look("both_a", 64'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
        look("both_b", 64'h8000_0084, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0);
        look("evict_miss", 64'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        set_beats(32'hB0, 32'h1);
        serve("stall", 64'h8000_0100, 3, 1, -1);
        look("kept_way1", 64'h8000_0080, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0);
        look("gap_line", 64'h8000_0108, 1'b1, 1'b0, 1'b1, 32'hB2, 1'b0);
        look("evicted", 64'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        set_beats(32'h11, 32'h11);
        serve("refetch", 64'h8000_0000, 0, 0, -1);
        look("refetch_hit", 64'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
        look("b_still", 64'h8000_0104, 1'b1, 1'b0, 1'b1, 32'hB1, 1'b0);

        // Flush while idle overrides a hit and starts no refill.
        look("flush_idle", 64'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        look("after_flush", 64'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chkb("after_flush/no_req", MemReqValid, 1'b0);

        // Flush coincident with the last beat discards the line.
        look("flushed_b", 64'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        set_beats(32'hC0, 32'h1);
        serve("flush_last", 64'h8000_0100, 0, 0, 3);
        look("discard_last", 64'h8000_0100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        serve("refill_c", 64'h8000_0100, 0, 0, -1);
        look("c_hit", 64'h8000_010C, 1'b1, 1'b0, 1'b1, 32'hC3, 1'b0);

        // Flush mid-burst: burst drains, line stays invalid, request reissued.
        look("flushed_a", 64'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        set_beats(32'h11, 32'h11);
        serve("flush_recv", 64'h8000_0000, 1, 1, 2);
        look("discard_recv", 64'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        serve("reissue", 64'h8000_0000, 0, 0, -1);
        look("reissue_hit", 64'h8000_0004, 1'b1, 1'b0, 1'b1, 32'h22, 1'b0);

        // Reset dropped in the middle of a burst.
        look("rst_miss", 64'h8000_0200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge Clk); MemReqReady = 1'b1; #2;
        chkb("rst/req_valid", MemReqValid, 1'b1);
        @(negedge Clk); MemReqReady = 1'b0; MemRspValid = 1'b1; MemRspData = 32'h55; #2;
        chkb("rst/recv_stall", CacheMiss, 1'b1);
        @(negedge Clk); MemRspData = 32'h66; Rst = 1'b0; PcValid = 1'b0; #2;
        @(negedge Clk); Rst = 1'b1; MemRspData = 32'h77; #2;
        chkb("rst/req_low", MemReqValid, 1'b0);
        chkb("rst/inst_valid", InstValid, 1'b0);
        chkb("rst/cache_miss", CacheMiss, 1'b0);
        look("rst_lost_a", 64'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized run against the line-level model.
        Rst = 1'b0;
        cyc(64'h0, 1'b0, 1'b0);
        cyc(64'h0, 1'b0, 1'b0);
        Rst = 1'b1;
        for (int s = 0; s < 8; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_val[s][w] = 1'b0;
                m_tag[s][w] = '0;
            end
        end

        for (int it = 0; it < 400; it++) begin
            pc  = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
            pv  = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 29) == 0);
            set = int'((pc >> 4) & 64'h7);
            tag = pc >> 7;
            hit = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (m_val[set][w] && (m_tag[set][w] == tag)) hit = 1'b1;
            end
            ev = pv && hit && !fl;
            look("rnd", pc, pv, fl, ev, ev ? mem_word(pc) : 32'h0, pv && !ev);
            if (fl) begin
                for (int s = 0; s < 8; s++) begin
                    m_val[s][0] = 1'b0;
                    m_val[s][1] = 1'b0;
                end
            end else if (pv && !hit) begin
                if (!m_val[set][0])      victim = 0;
                else if (!m_val[set][1]) victim = 1;
                else                     victim = m_rr[set];
                line = pc & ~64'hF;
                for (int i = 0; i < 4; i++) beat_buf[i] = mem_word(line + 64'(i * 4));
                fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
                serve("rnd_fill", line, int'($urandom_range(0, 2)), 2, fa);
                m_rr[set] = (victim + 1) % 2;
                if (fa >= 0) begin
                    for (int s = 0; s < 8; s++) begin
                        m_val[s][0] = 1'b0;
                        m_val[s][1] = 1'b0;
                    end
                end else begin
                    m_val[set][victim] = 1'b1;
                    m_tag[set][victim] = tag;
                end
            end
        end

        cyc(64'h0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
